// File: rtl/mrd_tag_pool.sv
// Shared MRd tag pool: round-robin channel arbiter feeding a lowest-free-tag bitmap allocator.
// Latency: a request seen at edge k gives a one-cycle grant pulse in cycle k+1; at most one grant per 3 cycles.
// Backpressure: with no free tag, requests stay pending without a pulse until a release frees a tag.
module mrd_tag_pool #(
    parameter int NUM_CHAN = 4,
    parameter int NUM_TAGS = 32
) (
    input  logic                s_axi_clk,
    input  logic                s_axi_rstn,
    input  logic [NUM_CHAN-1:0] alloc_tag_req,
    output logic [NUM_CHAN-1:0] allocated_tag_rdy,
    output logic [7:0]          allocated_tag,
    input  logic                tag_release_valid,
    input  logic [7:0]          tag_release_tag,
    input  logic                flush_all,
    output logic [8:0]          free_count,
    output logic                tags_empty,
    output logic                err_bad_release
);

    localparam int CW = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int TW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       win_idx;
    logic                win_found;
    logic [NUM_TAGS-1:0] bitmap, bitmap_nxt;
    logic [TW-1:0]       tag_idx;
    logic                tag_found;
    logic                do_alloc;
    logic [NUM_CHAN-1:0] req_masked;
    logic [TW-1:0]       rel_slot;
    logic                rel_in_range;
    logic                rel_ok;
    logic                rel_bad;
    logic [8:0]          count_nxt;

    // Only IDLE may start a grant, so the winner's dropped request in HOLD never counts.
    assign req_masked = (state == IDLE) ? alloc_tag_req : '0;

    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        for (int k = 1; k <= NUM_CHAN; k++) begin
            if (!win_found && req_masked[CW'((int'(rr_ptr) + k) % NUM_CHAN)]) begin
                win_found = 1'b1;
                win_idx   = CW'((int'(rr_ptr) + k) % NUM_CHAN);
            end
        end
    end

    always_comb begin
        tag_idx   = '0;
        tag_found = |bitmap;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (bitmap[i]) begin
                tag_idx = TW'(i);
            end
        end
    end

    // A release is legal only for an in-range tag that is currently handed out.
    assign rel_slot     = tag_release_tag[TW-1:0];
    assign rel_in_range = ({1'b0, tag_release_tag} < 9'(NUM_TAGS));
    assign rel_ok       = tag_release_valid && rel_in_range && !bitmap[rel_slot];
    assign rel_bad      = tag_release_valid && !(rel_in_range && !bitmap[rel_slot]);

    always_comb begin
        state_nxt = state;
        do_alloc  = 1'b0;
        case (state)
            IDLE: begin
                if (win_found && tag_found) begin
                    do_alloc  = 1'b1;
                    state_nxt = GRANT;
                end
            end
            GRANT:   state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_all) begin
            do_alloc  = 1'b0;
            state_nxt = IDLE;
        end
    end

    // Allocation picks from the pre-edge bitmap, so a tag released on the same edge is not re-granted.
    always_comb begin
        bitmap_nxt = bitmap;
        if (do_alloc) begin
            bitmap_nxt[tag_idx] = 1'b0;
        end
        if (rel_ok) begin
            bitmap_nxt[rel_slot] = 1'b1;
        end
    end

    assign count_nxt = free_count + {8'd0, rel_ok} - {8'd0, do_alloc};

    always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
        if (!s_axi_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_rstn) begin
        if (!s_axi_rstn) begin
            bitmap            <= '1;
            free_count        <= 9'(NUM_TAGS);
            allocated_tag_rdy <= '0;
            allocated_tag     <= '0;
            rr_ptr            <= CW'(NUM_CHAN - 1);
            err_bad_release   <= 1'b0;
        end else if (flush_all) begin
            bitmap            <= '1;
            free_count        <= 9'(NUM_TAGS);
            allocated_tag_rdy <= '0;
        end else begin
            bitmap            <= bitmap_nxt;
            free_count        <= count_nxt;
            allocated_tag_rdy <= do_alloc ? (NUM_CHAN'(1) << win_idx) : '0;
            if (do_alloc) begin
                allocated_tag <= 8'(tag_idx);
                rr_ptr        <= win_idx;
            end
            if (rel_bad) begin
                err_bad_release <= 1'b1;
            end
        end
    end

    assign tags_empty = (free_count == 9'd0);

endmodule

// File: tb/tb_mrd_tag_pool.sv
// Bench for mrd_tag_pool: directed scenarios then random traffic, checked against a free-set model.
module tb_mrd_tag_pool;

    localparam int NC = 4;
    localparam int NT = 32;

    logic          s_axi_clk = 1'b0;
    logic          s_axi_rstn;
    logic [NC-1:0] alloc_tag_req;
    logic [NC-1:0] allocated_tag_rdy;
    logic [7:0]    allocated_tag;
    logic          tag_release_valid;
    logic [7:0]    tag_release_tag;
    logic          flush_all;
    logic [8:0]    free_count;
    logic          tags_empty;
    logic          err_bad_release;

    mrd_tag_pool #(.NUM_CHAN(NC), .NUM_TAGS(NT)) dut (
        .s_axi_clk         (s_axi_clk),
        .s_axi_rstn        (s_axi_rstn),
        .alloc_tag_req     (alloc_tag_req),
        .allocated_tag_rdy (allocated_tag_rdy),
        .allocated_tag     (allocated_tag),
        .tag_release_valid (tag_release_valid),
        .tag_release_tag   (tag_release_tag),
        .flush_all         (flush_all),
        .free_count        (free_count),
        .tags_empty        (tags_empty),
        .err_bad_release   (err_bad_release)
    );

    always #5 s_axi_clk = ~s_axi_clk;

    // Reference model: set of free tags, arbiter cooldown after each grant, round-robin pointer.
    bit            mfree[NT];
    int            mptr;
    int            mcool;
    bit            merr;
    logic [NC-1:0] erdy;
    logic [7:0]    etag;

    // Requester emulation and bookkeeping.
    bit  want[NC];
    bit  once[NC];
    int  drop[NC];
    int  outq[$];
    int  cyc;
    bit  got;
    int  g_chan, g_tag, g_cyc;
    int  errors = 0;
    int  checks = 0;

    function automatic int nfree();
        int n = 0;
        foreach (mfree[i]) if (mfree[i]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic mreset();
        foreach (mfree[i]) mfree[i] = 1'b1;
        mptr  = NC - 1;
        mcool = 0;
        merr  = 1'b0;
        erdy  = '0;
        etag  = '0;
    endtask

    task automatic model_step(input logic [NC-1:0] req, input bit rv, input int rt, input bit fl);
        bit rel_ok;
        erdy = '0;
        if (fl) begin
            foreach (mfree[i]) mfree[i] = 1'b1;
            mcool = 0;
            return;
        end
        rel_ok = 1'b0;
        if (rv) begin
            if (rt < NT) rel_ok = !mfree[rt];
            if (!rel_ok) merr = 1'b1;
        end
        if (mcool > 0) begin
            mcool--;
        end else if (req != '0 && nfree() > 0) begin
            int w = 0;
            int t = 0;
            for (int k = 1; k <= NC; k++) begin
                if (req[(mptr + k) % NC]) begin
                    w = (mptr + k) % NC;
                    break;
                end
            end
            for (int i = 0; i < NT; i++) begin
                if (mfree[i]) begin
                    t = i;
                    break;
                end
            end
            mfree[t] = 1'b0;
            erdy[w]  = 1'b1;
            etag     = 8'(t);
            mptr     = w;
            mcool    = 2;
        end
        if (rel_ok) mfree[rt] = 1'b1;
    endtask

    task automatic cycle();
        logic [NC-1:0] req;
        for (int c = 0; c < NC; c++) req[c] = want[c] && (drop[c] == 0);
        alloc_tag_req = req;
        model_step(req, tag_release_valid, int'(tag_release_tag), flush_all);
        @(posedge s_axi_clk);
        #1;
        cyc++;
        if (flush_all) outq.delete();
        tag_release_valid = 1'b0;
        flush_all         = 1'b0;
        chk("rdy", 32'(allocated_tag_rdy), 32'(erdy));
        chk("tag", 32'(allocated_tag), 32'(etag));
        chk("free_count", 32'(free_count), 32'(nfree()));
        chk("tags_empty", 32'(tags_empty), 32'(nfree() == 0));
        chk("err", 32'(err_bad_release), 32'(merr));
        got = 1'b0;
        for (int c = 0; c < NC; c++) begin
            if (drop[c] > 0) drop[c]--;
            if (allocated_tag_rdy[c] === 1'b1) begin
                drop[c] = 2;
                if (once[c]) want[c] = 1'b0;
                got    = 1'b1;
                g_chan = c;
                g_tag  = int'(allocated_tag);
                g_cyc  = cyc;
                outq.push_back(int'(allocated_tag));
            end
        end
    endtask

    task automatic wait_grant(input int budget);
        int n = 0;
        cycle();
        while (!got && n < budget) begin
            cycle();
            n++;
        end
        chk("wait_grant", 32'(got), 32'd1);
    endtask

    task automatic drop_from_outq(input int t);
        for (int i = 0; i < outq.size(); i++) begin
            if (outq[i] == t) begin
                outq.delete(i);
                break;
            end
        end
    endtask

    task automatic release_tag(input int t);
        tag_release_valid = 1'b1;
        tag_release_tag   = 8'(t);
        drop_from_outq(t);
    endtask

    task automatic do_reset();
        s_axi_rstn        = 1'b0;
        alloc_tag_req     = '0;
        tag_release_valid = 1'b0;
        tag_release_tag   = '0;
        flush_all         = 1'b0;
        for (int c = 0; c < NC; c++) begin
            want[c] = 1'b0;
            once[c] = 1'b0;
            drop[c] = 0;
        end
        outq.delete();
        mreset();
        @(posedge s_axi_clk);
        #1;
        chk("reset_rdy", 32'(allocated_tag_rdy), 32'd0);
        chk("reset_tag", 32'(allocated_tag), 32'd0);
        chk("reset_free_count", 32'(free_count), 32'(NT));
        chk("reset_tags_empty", 32'(tags_empty), 32'd0);
        chk("reset_err", 32'(err_bad_release), 32'd0);
        s_axi_rstn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_c[4] = '{0, 1, 3, 0};
        int exp_t[4] = '{0, 1, 2, 3};
        int prev;
        cyc = 0;

        // Single request, then a second one.
        do_reset();
        want[0] = 1'b1; once[0] = 1'b1;
        cycle();
        chk("t1_rdy", 32'(allocated_tag_rdy), 32'b0001);
        chk("t1_tag", 32'(allocated_tag), 32'd0);
        chk("t1_count", 32'(free_count), 32'd31);
        want[0] = 1'b1; once[0] = 1'b1;
        wait_grant(10);
        chk("t1_second_tag", 32'(g_tag), 32'd1);

        // Round-robin across channels 0, 1 and 3.
        do_reset();
        want[0] = 1'b1; want[1] = 1'b1; want[3] = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(10);
            chk("rr_chan", 32'(g_chan), 32'(exp_c[k]));
            chk("rr_tag", 32'(g_tag), 32'(exp_t[k]));
            if (k > 0) chk("rr_gap", 32'(g_cyc - prev), 32'd3);
            prev = g_cyc;
        end

        // Exhaust the pool, hold a pending request, free one tag.
        do_reset();
        want[2] = 1'b1;
        for (int k = 0; k < NT; k++) wait_grant(10);
        cycle();
        cycle();
        chk("ex_count", 32'(free_count), 32'd0);
        chk("ex_empty", 32'(tags_empty), 32'd1);
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("ex_no_rdy", 32'(allocated_tag_rdy), 32'd0);
        end
        release_tag(2);
        cycle();
        chk("ex_rel_count", 32'(free_count), 32'd1);
        wait_grant(10);
        chk("ex_chan", 32'(g_chan), 32'd2);
        chk("ex_tag", 32'(g_tag), 32'd2);

        // Release and allocate on the same edge.
        do_reset();
        want[0] = 1'b1;
        for (int k = 0; k < 30; k++) wait_grant(10);
        want[0] = 1'b0;
        cycle();
        cycle();
        release_tag(3);
        cycle();
        chk("sim_pre_count", 32'(free_count), 32'd3);
        want[0] = 1'b1; once[0] = 1'b1;
        release_tag(7);
        cycle();
        chk("sim_rdy", 32'(allocated_tag_rdy), 32'b0001);
        chk("sim_tag", 32'(allocated_tag), 32'd3);
        chk("sim_count", 32'(free_count), 32'd3);
        want[0] = 1'b1; once[0] = 1'b1;
        wait_grant(10);
        chk("sim_next_tag", 32'(g_tag), 32'd7);

        // Bad releases set the sticky error.
        do_reset();
        tag_release_valid = 1'b1; tag_release_tag = 8'd5;
        cycle();
        chk("bad_free_err", 32'(err_bad_release), 32'd1);
        chk("bad_free_count", 32'(free_count), 32'(NT));
        tag_release_valid = 1'b1; tag_release_tag = 8'd40;
        cycle();
        chk("bad_range_err", 32'(err_bad_release), 32'd1);
        cycle();
        chk("bad_sticky", 32'(err_bad_release), 32'd1);

        // Flush with outstanding tags and a pending request.
        do_reset();
        want[0] = 1'b1;
        for (int k = 0; k < 10; k++) wait_grant(10);
        want[0] = 1'b0;
        cycle();
        cycle();
        want[1] = 1'b1; once[1] = 1'b1;
        flush_all = 1'b1;
        cycle();
        chk("fl_count", 32'(free_count), 32'(NT));
        chk("fl_no_rdy", 32'(allocated_tag_rdy), 32'd0);
        wait_grant(10);
        chk("fl_chan", 32'(g_chan), 32'd1);
        chk("fl_tag", 32'(g_tag), 32'd0);

        // Flush landing on a visible grant frees that tag.
        want[2] = 1'b1; once[2] = 1'b1;
        wait_grant(10);
        flush_all = 1'b1;
        cycle();
        chk("flg_count", 32'(free_count), 32'(NT));

        // Asynchronous reset in the middle of a grant pulse.
        want[3] = 1'b1; once[3] = 1'b1;
        wait_grant(10);
        #2;
        s_axi_rstn = 1'b0;
        #1;
        chk("arst_rdy", 32'(allocated_tag_rdy), 32'd0);
        chk("arst_count", 32'(free_count), 32'(NT));
        do_reset();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            int r;
            if (i == 750) do_reset();
            for (int c = 0; c < NC; c++) begin
                if (!want[c] && $urandom_range(0, 3) == 0) begin
                    want[c] = 1'b1;
                    once[c] = 1'b1;
                end
            end
            r = $urandom_range(0, 99);
            if (r < 28 && outq.size() > 0) begin
                int idx = $urandom_range(0, outq.size() - 1);
                tag_release_valid = 1'b1;
                tag_release_tag   = 8'(outq[idx]);
                outq.delete(idx);
            end else if (r == 30) begin
                tag_release_valid = 1'b1;
                tag_release_tag   = 8'($urandom_range(NT, 255));
            end else if (r == 31) begin
                int t = $urandom_range(0, NT - 1);
                tag_release_valid = 1'b1;
                tag_release_tag   = 8'(t);
                drop_from_outq(t);
            end
            if ($urandom_range(0, 299) == 0) flush_all = 1'b1;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mrd_tag_pool.md
Name: mrd_tag_pool

Overview:
- Shared MRd tag allocator and arbiter serving up to NUM_CHAN C2S/S2C channels.
- Each channel's mrd_requestor drives a request line; the pool grants channels round-robin and hands out the lowest-numbered free tag from a bitmap.
- The completion path returns tags when the last completion of a burst arrives.
- A flush returns every tag to the pool on a global abort.

Parameters:
- NUM_CHAN, 4, number of requesting channels (1..16).
- NUM_TAGS, 32, number of usable tags (1..256); tags run 0..NUM_TAGS-1.

Ports:
- s_axi_clk  in  1  clock for all logic.
- s_axi_rstn  in  1  reset; asynchronous assert, active-low.
- alloc_tag_req  in  NUM_CHAN  per-channel level request; held until the matching rdy pulse.
- allocated_tag_rdy  out  NUM_CHAN  one-hot, one-cycle grant pulse.
- allocated_tag  out  8  granted tag; valid while any allocated_tag_rdy bit is high.
- tag_release_valid  in  1  one-cycle pulse: return tag_release_tag.
- tag_release_tag  in  8  tag being returned.
- flush_all  in  1  one-cycle pulse: mark all tags free and abort arbitration.
- free_count  out  9  number of currently free tags.
- tags_empty  out  1  high when free_count == 0.
- err_bad_release  out  1  sticky error flag; cleared only by reset.

Behaviour:
- One clock domain; reset is asynchronous and active-low (s_axi_rstn).
- Reset values:
  - allocated_tag_rdy = 0, allocated_tag = 0, err_bad_release = 0.
  - Bitmap all free, free_count = NUM_TAGS, tags_empty = 0.
  - State IDLE, round-robin pointer = NUM_CHAN-1, so channel 0 wins first.
- FSM states: IDLE, GRANT, HOLD.
  - IDLE: if the masked request vector is nonzero and the bitmap is nonzero, then at the edge:
    - Pick winner w = first requester searching from pointer+1 with wraparound.
    - Pick tag t = lowest set bitmap bit; clear that bit.
    - Register allocated_tag = t and allocated_tag_rdy = 1<<w.
    - Set pointer = w and go to GRANT.
  - IDLE otherwise: stay.
  - GRANT: allocated_tag_rdy is high for exactly this cycle; go to HOLD.
  - HOLD: the request from w is masked, since the requester drops it this cycle; go to IDLE.
- Latency and throughput:
  - Request visible at edge k → rdy high in cycle k+1.
  - At most one grant per 3 cycles.
  - Other channels are not masked in HOLD but wait for IDLE.
- allocated_tag holds its last value between grants.
- Empty pool: requests stay pending, no rdy is issued, requesters are not dropped.
  - The first release re-enables allocation; the grant goes at the next IDLE edge after the bitmap bit is set.
- Release:
  - A valid release of tag r, where r < NUM_TAGS and r is currently allocated, sets bitmap[r] at the edge.
  - If r >= NUM_TAGS or r is already free, the release is ignored and err_bad_release is set.
- Simultaneous allocation and release in the same edge:
  - The allocation decision uses the pre-edge bitmap.
  - The released tag is not re-granted in that same edge.
  - free_count is unchanged (+1 and -1 cancel).
- free_count arithmetic: 9-bit, never exceeds NUM_TAGS, never underflows. A bad release does not change it.
- flush_all has priority over release and allocation:
  - At the edge: bitmap all free, free_count = NUM_TAGS, state IDLE, no new decision.
  - Pointer is kept.
  - A grant registered at the edge before the flush is still output in the flush cycle; its tag is freed by the flush.
- Asynchronous reset mid-grant: rdy deasserts immediately; all state returns to reset values.

Test Plan:
1. Reset, NUM_TAGS=32. Raise alloc_tag_req[0] → allocated_tag_rdy=4'b0001 one cycle later, allocated_tag=0, free_count=31. Requester drops req; a second request gets tag 1.
2. Round-robin. Hold req[0], req[1] and req[3] continuously, dropping each one only for the cycle after its rdy pulse. Grants go to channel 0 (tag 0), 1 (tag 1), 3 (tag 2), 0 (tag 3), 3 cycles apart.
3. Exhaustion, NUM_TAGS=4.
   - Grant 4 tags → tags_empty=1, free_count=0.
   - A fifth req[2] stays pending with no rdy.
   - Release tag 2 → free_count=1, then req[2] gets tag 2.
4. Simultaneous, free_count=5. Release tag 7 on the same edge as a grant of tag 3 → free_count stays 5; tag 7 is granted on the next request, not tag 3.
5. Bad release, NUM_TAGS=32.
   - Release tag 5 while free → err_bad_release=1, free_count unchanged.
   - Release tag 40 → still 1; only reset clears it.
6. Flush with 10 tags outstanding and a pending req[1]: pulse flush_all → free_count=32 next cycle, state IDLE. The next grant to channel 1 carries tag 0.
